// File: rtl/rob_mp.sv
// rob_mp: parametrised reorder buffer with independent dispatch, writeback and commit widths.
// Define ROB_EXCEPTION_EN to add per-entry exception flags that terminate the commit chain.
module rob_mp #(
    parameter int ROB_DEPTH    = 64,
    parameter int P_ADDR_WIDTH = 7,
    parameter int DISP_WIDTH   = 2,
    parameter int WB_PORTS     = 4,
    parameter int COMMIT_WIDTH = 2,
    localparam int ID_W        = $clog2(ROB_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DISP_WIDTH-1:0]              disp_valid,
    output logic                               disp_ready,
    input  logic [DISP_WIDTH*P_ADDR_WIDTH-1:0] disp_ppdst,
    output logic [DISP_WIDTH*ID_W-1:0]         disp_id,
    input  logic [WB_PORTS-1:0]                wb_en,
    input  logic [WB_PORTS*ID_W-1:0]           wb_id,
`ifdef ROB_EXCEPTION_EN
    input  logic [WB_PORTS-1:0]                wb_exc,
    output logic [COMMIT_WIDTH-1:0]            commit_exc,
`endif
    output logic [COMMIT_WIDTH-1:0]            commit_valid,
    input  logic [COMMIT_WIDTH-1:0]            commit_pop,
    output logic [COMMIT_WIDTH*P_ADDR_WIDTH-1:0] commit_ppdst,
    output logic [COMMIT_WIDTH*ID_W-1:0]       commit_id,
    input  logic                               rec_en,
    input  logic [ID_W-1:0]                    rec_id,
    output logic [ID_W:0]                      count,
    output logic                               empty,
    output logic                               full
);

    localparam int CW = ID_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(ROB_DEPTH);
    localparam logic [CW-1:0] DISP_C  = CW'(DISP_WIDTH);

    if (ROB_DEPTH < 2 * DISP_WIDTH) begin : g_depth_chk
        $error("rob_mp: ROB_DEPTH must be at least 2*DISP_WIDTH");
    end
    if (COMMIT_WIDTH > ROB_DEPTH) begin : g_commit_chk
        $error("rob_mp: COMMIT_WIDTH must not exceed ROB_DEPTH");
    end

    logic [ID_W-1:0]         head;
    logic [ID_W-1:0]         tail;
    logic [CW-1:0]           cnt_q;
    logic [ROB_DEPTH-1:0]    exec;
    logic [P_ADDR_WIDTH-1:0] ppdst_mem [ROB_DEPTH];
`ifdef ROB_EXCEPTION_EN
    logic [ROB_DEPTH-1:0]    exc;
`endif

    logic                    push_fire;
    logic [CW-1:0]           n_push;
    logic [CW-1:0]           n_pop;
    logic [CW-1:0]           rec_dist;
    logic [ID_W-1:0]         disp_idx [DISP_WIDTH];

    // Operands are always below ROB_DEPTH, so one conditional subtract suffices
    // and the result never depends on power-of-two wrap.
    function automatic logic [ID_W-1:0] mod_add(input logic [ID_W-1:0] a, input logic [CW-1:0] b);
        logic [CW-1:0] s;
        s = {1'b0, a} + b;
        if (s >= DEPTH_C) begin
            s = s - DEPTH_C;
        end
        return s[ID_W-1:0];
    endfunction

    assign disp_ready = (DEPTH_C - cnt_q) >= DISP_C;
    assign push_fire  = disp_ready && !rec_en;
    assign count      = cnt_q;
    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == DEPTH_C);

    always_comb begin
        n_push  = '0;
        disp_id = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            disp_idx[i] = mod_add(tail, CW'(i));
            disp_id[i*ID_W +: ID_W] = disp_idx[i];
            if (push_fire && disp_valid[i]) begin
                n_push = n_push + CW'(1);
            end
        end
    end

    always_comb begin
        n_pop = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_pop[i]) begin
                n_pop = n_pop + CW'(1);
            end
        end
    end

    always_comb begin
        if (rec_id >= head) begin
            rec_dist = {1'b0, rec_id} - {1'b0, head};
        end else begin
            rec_dist = {1'b0, rec_id} + DEPTH_C - {1'b0, head};
        end
    end

    always_comb begin
        logic            chain;
        logic [ID_W-1:0] c_idx;
        chain        = 1'b1;
        commit_valid = '0;
        commit_ppdst = '0;
        commit_id    = '0;
`ifdef ROB_EXCEPTION_EN
        commit_exc   = '0;
`endif
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            c_idx = mod_add(head, CW'(i));
            commit_id[i*ID_W +: ID_W]                 = c_idx;
            commit_ppdst[i*P_ADDR_WIDTH +: P_ADDR_WIDTH] = ppdst_mem[c_idx];
            chain           = chain && (CW'(i) < cnt_q) && exec[c_idx];
            commit_valid[i] = chain;
`ifdef ROB_EXCEPTION_EN
            // An excepting entry retires alone; everything younger waits.
            commit_exc[i] = exc[c_idx];
            chain         = chain && !exc[c_idx];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
            exec  <= '0;
`ifdef ROB_EXCEPTION_EN
            exc   <= '0;
`endif
        end else begin
            head <= mod_add(head, n_pop);
            if (rec_en) begin
                tail  <= rec_id;
                cnt_q <= rec_dist - n_pop;
            end else begin
                tail  <= mod_add(tail, n_push);
                cnt_q <= cnt_q + n_push - n_pop;
            end
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_en[k]) begin
                    exec[wb_id[k*ID_W +: ID_W]] <= 1'b1;
`ifdef ROB_EXCEPTION_EN
                    if (wb_exc[k]) begin
                        exc[wb_id[k*ID_W +: ID_W]] <= 1'b1;
                    end
`endif
                end
            end
            // Placed after writeback so a same-cycle allocation overrides it.
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (push_fire && disp_valid[i]) begin
                    exec[disp_idx[i]] <= 1'b0;
`ifdef ROB_EXCEPTION_EN
                    exc[disp_idx[i]]  <= 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (push_fire && disp_valid[i]) begin
                ppdst_mem[disp_idx[i]] <= disp_ppdst[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_rob_mp.sv
// tb_rob_mp: directed scenarios plus randomized traffic against a ring-buffer model of rob_mp.
module tb_rob_mp;
    localparam int DEPTH = 6;
    localparam int PW    = 7;
    localparam int DW    = 2;
    localparam int WBP   = 2;
    localparam int CWD   = 2;
    localparam int IDW   = $clog2(DEPTH);
    localparam int CNTW  = IDW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     disp_valid;
    logic              disp_ready;
    logic [DW*PW-1:0]  disp_ppdst;
    logic [DW*IDW-1:0] disp_id;
    logic [WBP-1:0]    wb_en;
    logic [WBP*IDW-1:0] wb_id;
`ifdef ROB_EXCEPTION_EN
    logic [WBP-1:0]    wb_exc;
    logic [CWD-1:0]    commit_exc;
`endif
    logic [CWD-1:0]    commit_valid;
    logic [CWD-1:0]    commit_pop;
    logic [CWD*PW-1:0] commit_ppdst;
    logic [CWD*IDW-1:0] commit_id;
    logic              rec_en;
    logic [IDW-1:0]    rec_id;
    logic [IDW:0]      count;
    logic              empty;
    logic              full;

    int errors = 0;
    int checks = 0;

    int          m_head, m_tail, m_count;
    bit          m_exec  [DEPTH];
    logic [PW-1:0] m_ppdst [DEPTH];
`ifdef ROB_EXCEPTION_EN
    bit          m_exc   [DEPTH];
`endif

    rob_mp #(
        .ROB_DEPTH(DEPTH), .P_ADDR_WIDTH(PW), .DISP_WIDTH(DW),
        .WB_PORTS(WBP), .COMMIT_WIDTH(CWD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ppdst(disp_ppdst), .disp_id(disp_id),
        .wb_en(wb_en), .wb_id(wb_id),
`ifdef ROB_EXCEPTION_EN
        .wb_exc(wb_exc), .commit_exc(commit_exc),
`endif
        .commit_valid(commit_valid), .commit_pop(commit_pop),
        .commit_ppdst(commit_ppdst), .commit_id(commit_id),
        .rec_en(rec_en), .rec_id(rec_id),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic idle();
        disp_valid = '0;
        disp_ppdst = '0;
        wb_en      = '0;
        wb_id      = '0;
        commit_pop = '0;
        rec_en     = 1'b0;
        rec_id     = '0;
`ifdef ROB_EXCEPTION_EN
        wb_exc     = '0;
`endif
    endtask

    // Advances the ring model by one clock from the inputs currently applied.
    task automatic model_step();
        int np, npop, idx, d;
        np = 0;
        npop = 0;
        if ((DEPTH - m_count) >= DW && !rec_en)
            for (int i = 0; i < DW; i++) if (disp_valid[i]) np++;
        for (int i = 0; i < CWD; i++) if (commit_pop[i]) npop++;
        for (int k = 0; k < WBP; k++) begin
            if (wb_en[k]) begin
                m_exec[int'(wb_id[k*IDW +: IDW])] = 1'b1;
`ifdef ROB_EXCEPTION_EN
                if (wb_exc[k]) m_exc[int'(wb_id[k*IDW +: IDW])] = 1'b1;
`endif
            end
        end
        for (int i = 0; i < np; i++) begin
            idx = (m_tail + i) % DEPTH;
            m_exec[idx]  = 1'b0;
            m_ppdst[idx] = disp_ppdst[i*PW +: PW];
`ifdef ROB_EXCEPTION_EN
            m_exc[idx]   = 1'b0;
`endif
        end
        if (rec_en) begin
            d       = (int'(rec_id) - m_head + DEPTH) % DEPTH;
            m_count = d - npop;
            m_tail  = int'(rec_id);
        end else begin
            m_count = m_count + np - npop;
            m_tail  = (m_tail + np) % DEPTH;
        end
        m_head = (m_head + npop) % DEPTH;
    endtask

    task automatic tick();
        checks++;
        if (((commit_pop & (commit_pop + 1'b1)) != '0) || ((commit_pop & ~commit_valid) != '0)) begin
            errors++;
            $display("FAIL pop_legal: commit_pop=%b commit_valid=%b", commit_pop, commit_valid);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        m_head = 0; m_tail = 0; m_count = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_exec[i] = 1'b0;
`ifdef ROB_EXCEPTION_EN
            m_exc[i] = 1'b0;
`endif
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_commit_valid: got %b want 00", commit_valid); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", empty, full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (disp_id !== {3'd1, 3'd0}) begin errors++; $display("FAIL reset_disp_id: got %h want 08", disp_id); end
    endtask

    task automatic test_fill();
        logic [DW*IDW-1:0] exp_id;
        for (int s = 0; s < 3; s++) begin
            disp_valid = 2'b11;
            disp_ppdst = {7'(11 + 2*s), 7'(10 + 2*s)};
            exp_id = {3'(2*s + 1), 3'(2*s)};
            checks++; if (disp_id !== exp_id) begin errors++; $display("FAIL fill_disp_id[%0d]: got %h want %h", s, disp_id, exp_id); end
            tick();
        end
        idle();
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL fill_count: got %0d want 6", count); end
        checks++; if (full !== 1'b1 || disp_ready !== 1'b0) begin errors++; $display("FAIL fill_full: full=%b ready=%b want 1/0", full, disp_ready); end
        disp_valid = 2'b11;
        disp_ppdst = {7'd99, 7'd98};
        tick();
        idle();
        checks++; if (count !== 4'd6 || disp_id !== {3'd1, 3'd0}) begin errors++; $display("FAIL full_push_ignored: count=%0d disp_id=%h want 6/08", count, disp_id); end
    endtask

    task automatic test_writeback_commit();
        wb_en = 2'b11;
        wb_id = {3'd0, 3'd1};
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL wb_latency: got %b want 00", commit_valid); end
        tick();
        idle();
        checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL wb_commit_valid: got %b want 11", commit_valid); end
        checks++; if (commit_id !== {3'd1, 3'd0}) begin errors++; $display("FAIL wb_commit_id: got %h want 08", commit_id); end
        checks++; if (commit_ppdst !== {7'd11, 7'd10}) begin errors++; $display("FAIL wb_commit_ppdst: got %h want %h", commit_ppdst, {7'd11, 7'd10}); end
        commit_pop = 2'b11;
        tick();
        idle();
        checks++; if (count !== 4'd4 || disp_ready !== 1'b1) begin errors++; $display("FAIL pop_on_full: count=%0d ready=%b want 4/1", count, disp_ready); end
        checks++; if (commit_id[2:0] !== 3'd2) begin errors++; $display("FAIL pop_head: got %0d want 2", commit_id[2:0]); end
    endtask

    task automatic test_commit_gating();
        wb_en = 2'b01;
        wb_id = {3'd0, 3'd3};
        tick();
        idle();
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL gate_older_pending: got %b want 00", commit_valid); end
        wb_en = 2'b01;
        wb_id = {3'd0, 3'd2};
        tick();
        idle();
        checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL gate_release: got %b want 11", commit_valid); end
        commit_pop = 2'b11;
        tick();
        idle();
        checks++; if (count !== 4'd2 || commit_id[2:0] !== 3'd4) begin errors++; $display("FAIL gate_pop: count=%0d head=%0d want 2/4", count, commit_id[2:0]); end
    endtask

    task automatic test_flush_full();
        rec_en = 1'b1;
        rec_id = 3'd4;
        tick();
        idle();
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count: count=%0d empty=%b want 0/1", count, empty); end
        checks++; if (disp_id[2:0] !== 3'd4) begin errors++; $display("FAIL flush_tail: got %0d want 4", disp_id[2:0]); end
    endtask

    task automatic test_wrap();
        disp_valid = 2'b11;
        disp_ppdst = {7'd21, 7'd20};
        checks++; if (disp_id !== {3'd5, 3'd4}) begin errors++; $display("FAIL wrap_id_a: got %h want 2c", disp_id); end
        tick();
        disp_ppdst = {7'd23, 7'd22};
        checks++; if (disp_id !== {3'd1, 3'd0}) begin errors++; $display("FAIL wrap_id_b: got %h want 08", disp_id); end
        tick();
        idle();
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL wrap_count: got %0d want 4", count); end
        wb_en = 2'b11; wb_id = {3'd5, 3'd4};
        tick();
        wb_id = {3'd1, 3'd0};
        tick();
        idle();
        checks++; if (commit_valid !== 2'b11 || commit_id !== {3'd5, 3'd4} || commit_ppdst !== {7'd21, 7'd20}) begin
            errors++; $display("FAIL wrap_commit_a: valid=%b id=%h ppdst=%h", commit_valid, commit_id, commit_ppdst);
        end
        commit_pop = 2'b11;
        tick();
        idle();
        checks++; if (commit_valid !== 2'b11 || commit_id !== {3'd1, 3'd0} || commit_ppdst !== {7'd23, 7'd22}) begin
            errors++; $display("FAIL wrap_commit_b: valid=%b id=%h ppdst=%h", commit_valid, commit_id, commit_ppdst);
        end
        commit_pop = 2'b11;
        tick();
        idle();
        checks++; if (empty !== 1'b1 || count !== 4'd0 || disp_id[2:0] !== 3'd2 || commit_id[2:0] !== 3'd2) begin
            errors++; $display("FAIL wrap_drain: empty=%b count=%0d tail=%0d head=%0d want 1/0/2/2", empty, count, disp_id[2:0], commit_id[2:0]);
        end
    endtask

    task automatic test_recovery();
        disp_valid = 2'b11; tick();
        disp_valid = 2'b11; tick();
        idle();
        wb_en = 2'b11; wb_id = {3'd3, 3'd2}; tick();
        wb_id = {3'd5, 3'd4}; tick();
        idle();
        commit_pop = 2'b11; tick();
        commit_pop = 2'b11; tick();
        idle();
        checks++; if (count !== 4'd0 || disp_id[2:0] !== 3'd0) begin errors++; $display("FAIL rec_setup: count=%0d tail=%0d want 0/0", count, disp_id[2:0]); end
        disp_valid = 2'b11; disp_ppdst = {7'd31, 7'd30}; tick();
        disp_ppdst = {7'd33, 7'd32}; tick();
        disp_valid = 2'b01; disp_ppdst = {7'd0, 7'd34}; tick();
        idle();
        checks++; if (count !== 4'd5 || disp_id[2:0] !== 3'd5) begin errors++; $display("FAIL rec_fill: count=%0d tail=%0d want 5/5", count, disp_id[2:0]); end
        wb_en = 2'b01; wb_id = {3'd0, 3'd0}; tick();
        idle();
        checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL rec_pre_valid: got %b want 01", commit_valid); end
        rec_en = 1'b1; rec_id = 3'd2;
        disp_valid = 2'b11; disp_ppdst = {7'd77, 7'd76};
        commit_pop = 2'b01;
        tick();
        idle();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL rec_count: got %0d want 1", count); end
        checks++; if (disp_id[2:0] !== 3'd2) begin errors++; $display("FAIL rec_tail: got %0d want 2", disp_id[2:0]); end
        checks++; if (commit_id[2:0] !== 3'd1 || commit_ppdst[6:0] !== 7'd31 || commit_valid !== 2'b00) begin
            errors++; $display("FAIL rec_head: id=%0d ppdst=%0d valid=%b want 1/31/00", commit_id[2:0], commit_ppdst[6:0], commit_valid);
        end
    endtask

    task automatic test_random();
        logic [CWD-1:0] ev;
        bit ok;
        int idx, nv, np, nd, d;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ev = '0; ok = 1'b1; nv = 0;
            for (int i = 0; i < CWD; i++) begin
                idx = (m_head + i) % DEPTH;
                if (ok && i < m_count && m_exec[idx]) begin ev[i] = 1'b1; nv++; end
                else ok = 1'b0;
`ifdef ROB_EXCEPTION_EN
                if (ev[i] && m_exc[idx]) ok = 1'b0;
`endif
            end
            checks++; if (commit_valid !== ev) begin errors++; $display("FAIL rnd_commit_valid @%0d: got %b want %b", cyc, commit_valid, ev); end
            for (int i = 0; i < CWD; i++) begin
                if (ev[i]) begin
                    idx = (m_head + i) % DEPTH;
                    checks++; if (commit_id[i*IDW +: IDW] !== IDW'(idx)) begin errors++; $display("FAIL rnd_commit_id[%0d] @%0d: got %0d want %0d", i, cyc, commit_id[i*IDW +: IDW], idx); end
                    checks++; if (commit_ppdst[i*PW +: PW] !== m_ppdst[idx]) begin errors++; $display("FAIL rnd_commit_ppdst[%0d] @%0d: got %0d want %0d", i, cyc, commit_ppdst[i*PW +: PW], m_ppdst[idx]); end
`ifdef ROB_EXCEPTION_EN
                    checks++; if (commit_exc[i] !== m_exc[idx]) begin errors++; $display("FAIL rnd_commit_exc[%0d] @%0d: got %b want %b", i, cyc, commit_exc[i], m_exc[idx]); end
`endif
                end
            end
            checks++; if (count !== CNTW'(m_count)) begin errors++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, count, m_count); end
            checks++; if (disp_ready !== ((DEPTH - m_count) >= DW)) begin errors++; $display("FAIL rnd_disp_ready @%0d: got %b count=%0d", cyc, disp_ready, m_count); end
            checks++; if (full !== (m_count == DEPTH) || empty !== (m_count == 0)) begin errors++; $display("FAIL rnd_flags @%0d: full=%b empty=%b count=%0d", cyc, full, empty, m_count); end
            for (int i = 0; i < DW; i++) begin
                checks++; if (disp_id[i*IDW +: IDW] !== IDW'((m_tail + i) % DEPTH)) begin errors++; $display("FAIL rnd_disp_id[%0d] @%0d: got %0d want %0d", i, cyc, disp_id[i*IDW +: IDW], (m_tail + i) % DEPTH); end
            end
            nd = $urandom_range(0, DW);
            disp_valid = DW'((1 << nd) - 1);
            disp_ppdst = DW*PW'($urandom);
            for (int k = 0; k < WBP; k++) begin
                wb_en[k] = ($urandom_range(0, 2) != 0);
                wb_id[k*IDW +: IDW] = IDW'($urandom_range(0, DEPTH - 1));
`ifdef ROB_EXCEPTION_EN
                wb_exc[k] = ($urandom_range(0, 7) == 0);
`endif
            end
            np = $urandom_range(0, nv);
            commit_pop = CWD'((1 << np) - 1);
            rec_en = 1'b0;
            rec_id = '0;
            if ($urandom_range(0, 9) == 0 && m_count > 0 && np <= m_count - 1) begin
                d = $urandom_range(np, m_count - 1);
                rec_en = 1'b1;
                rec_id = IDW'((m_head + d) % DEPTH);
            end
            tick();
        end
        idle();
    endtask

`ifdef ROB_EXCEPTION_EN
    task automatic test_exception();
        test_reset();
        disp_valid = 2'b11; tick();
        idle();
        wb_en = 2'b11; wb_id = {3'd1, 3'd0}; wb_exc = 2'b01;
        tick();
        idle();
        checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL exc_chain: got %b want 01", commit_valid); end
        checks++; if (commit_exc[0] !== 1'b1) begin errors++; $display("FAIL exc_flag: got %b want 1", commit_exc[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_writeback_commit();
        test_commit_gating();
        test_flush_full();
        test_wrap();
        test_recovery();
        test_random();
`ifdef ROB_EXCEPTION_EN
        test_exception();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_mp.md
Name: rob_mp

Overview:
- Parametrised reorder buffer, successor of the 2-wide ROB.
- Independent dispatch, writeback and commit widths; any depth, including non-power-of-2.
- Explicit occupancy counter, so full and empty are unambiguous.
- Partial dispatch and partial commit per cycle, in-order commit gating on executed status, and flush-to-id recovery.
- Sits between rename/dispatch (allocates entries, receives ids) and the commit stage (frees old PPdst).

Parameters:
- ROB_DEPTH, 64, number of entries; any value ≥ 2·DISP_WIDTH.
- P_ADDR_WIDTH, 7, physical register address width.
- DISP_WIDTH, 2, entries allocatable per cycle.
- WB_PORTS, 4, writeback ports.
- COMMIT_WIDTH, 2, entries retireable per cycle; must be ≤ ROB_DEPTH.
- ID_W (localparam), $clog2(ROB_DEPTH), entry id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- disp_valid  in  DISP_WIDTH  thermometer (low-aligned) allocation request.
- disp_ready  out  1  room for DISP_WIDTH entries.
- disp_ppdst  in  DISP_WIDTH×P_ADDR_WIDTH  previous physical dst per slot.
- disp_id  out  DISP_WIDTH×ID_W  id assigned to slot i.
- wb_en  in  WB_PORTS  writeback strobe.
- wb_id  in  WB_PORTS×ID_W  entry being marked executed.
- commit_valid  out  COMMIT_WIDTH  thermometer of retireable entries.
- commit_pop  in  COMMIT_WIDTH  thermometer subset of commit_valid.
- commit_ppdst  out  COMMIT_WIDTH×P_ADDR_WIDTH  ppdst of head+i.
- commit_id  out  COMMIT_WIDTH×ID_W  id of head+i.
- rec_en  in  1  flush request.
- rec_id  in  ID_W  oldest entry to squash.
- count  out  ID_W+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==ROB_DEPTH.

Behaviour:
- State: head, tail (ID_W), count (ID_W+1), exec[ROB_DEPTH], ppdst[ROB_DEPTH].
- Reset: head=tail=count=0, exec all 0 (async). Outputs: disp_ready=1, commit_valid=0, empty=1, full=0, count=0. ppdst array is not reset.
- Modular add: (a+b) with a single conditional subtract of ROB_DEPTH. Never rely on natural ID_W wrap.
- disp_ready = (ROB_DEPTH−count) ≥ DISP_WIDTH; combinational from registered count.
- disp_id[i] = tail+i mod DEPTH; always driven, independent of valid.
- Push fires when disp_ready && !rec_en. n_push = popcount(disp_valid). Slot i writes ppdst[tail+i] and clears exec[tail+i]. tail += n_push next cycle.
- disp_valid while !disp_ready: ignored, no state change.
- Writeback: exec[wb_id[k]] <= 1, one cycle latency; visible in commit_valid the following cycle.
- Writeback to an entry allocated in the same cycle: allocation wins (exec=0).
- Duplicate wb_id across ports is legal. Writeback to an already-set entry keeps it at 1.
- commit_valid[i] = (i<count) && exec[head+i] && commit_valid[i−1]; combinational.
- commit_ppdst[i] / commit_id[i] read entry head+i; contents are don't-care when commit_valid[i]=0.
- n_pop = popcount(commit_pop). head += n_pop. A non-thermometer commit_pop, or commit_pop outside commit_valid, is illegal and flagged by a bench assertion.
- count_next = count + n_push − n_pop when !rec_en.
- Recovery (rec_en): highest priority over push; pushes that cycle are dropped. Pops that cycle are honoured.
  - tail <= rec_id.
  - count <= dist(head, rec_id) − n_pop, where dist = (rec_id−head) mod DEPTH.
  - rec_id==head means a full flush, count → 0.
  - rec_id must lie in [head, tail) and n_pop ≤ dist; otherwise illegal.
  - exec bits of squashed entries are left stale; they are cleared on re-allocation.
- Simultaneous full and push: disp_ready=0, so no allocation. Commit on a full ROB frees space, and disp_ready rises the next cycle.
- Head and tail wrap from DEPTH−1 to 0 for any depth. All arithmetic is done in ID_W+1 bits before the modulo.

Optional Feature:
- Macro: ROB_EXCEPTION_EN.
- When defined:
  - Adds input wb_exc[WB_PORTS]. exc[id] is set with exec, and cleared on allocation.
  - Adds output commit_exc[COMMIT_WIDTH] = exc[head+i].
  - commit_valid chain stops after the first excepting entry: that entry is valid, younger slots are 0.
- When undefined: no exc storage and no extra ports; behaviour as above.

Test Plan:
- DEPTH=6, DISP=2, COMMIT=2, WB=2 (all tests). Reset, then 3 pushes of 2 → disp_id 0/1, 2/3, 4/5; count=6, full=1, disp_ready=0.
- Writeback ids 1 and 0 at cycle t → commit_valid=2'b11 at t+1. Pop 2'b11 → head=2, count=4, disp_ready=1 next cycle.
- Wrap: with head=4, tail=4, count=0, push 2 then 2 → ids 4/5 then 0/1. Writeback all, pop both cycles → head=2, empty=1.
- Recovery: head=0, tail=5, rec_en with rec_id=2, simultaneous push and pop of entry 0 → tail=2, count=1, push dropped.
- Writeback only id 1 (id 0 not executed) → commit_valid=2'b00. Then writeback id 0 → 2'b11.
- ROB_EXCEPTION_EN: writeback ids 0, 1 with wb_exc on id 0 → commit_valid=2'b01, commit_exc[0]=1.
